// File: rtl/de_pkg.sv
// Shared definitions for the framestore drawing-engine port arbiter.
package de_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } de_state_e;

  localparam int          DE_ADDR_W         = 18;
  localparam int          DE_DATA_W         = 32;
  localparam logic [3:0]  DE_NBYTE_NONE     = 4'hF;
  localparam int          FRAMESTORE_STRIDE = 640;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!vld_o && req_i[IW'(j)]) begin
        vld_o            = 1'b1;
        gnt_o[IW'(j)]    = 1'b1;
        idx_o            = IW'(j);
      end
    end
  end

endmodule

// File: rtl/de_port_arbiter.sv
// Round-robin sharing of the single framestore de_* port between N_REQ drawing units,
// with one transaction latched at a time and an optional per-unit lock across transactions.
module de_port_arbiter
  import de_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = DE_ADDR_W,
  parameter int DATA_W = DE_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          u_req,
  input  logic [N_REQ-1:0]          u_lock,
  input  logic [N_REQ*ADDR_W-1:0]   u_addr,
  input  logic [N_REQ*4-1:0]        u_nbyte,
  input  logic [N_REQ-1:0]          u_rnw,
  input  logic [N_REQ*DATA_W-1:0]   u_w_data,
  output logic [N_REQ-1:0]          u_ack,
  output logic [DATA_W-1:0]         u_r_data,
  output logic                      de_req,
  input  logic                      de_ack,
  output logic [ADDR_W-1:0]         de_addr,
  output logic [3:0]                de_nbyte,
  output logic                      de_rnw,
  output logic [DATA_W-1:0]         de_w_data,
  input  logic [DATA_W-1:0]         de_r_data,
  output logic [N_REQ-1:0]          grant
);

  localparam int IW = $clog2(N_REQ);

  de_state_e          state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               lock_q, lock_d;
  logic [3:0]         tmo_q, tmo_d;
  logic               de_req_q, de_req_d;
  logic [ADDR_W-1:0]  de_addr_q, de_addr_d;
  logic [3:0]         de_nbyte_q, de_nbyte_d;
  logic               de_rnw_q, de_rnw_d;
  logic [DATA_W-1:0]  de_w_data_q, de_w_data_d;

  logic [N_REQ-1:0]   cand;
  logic [N_REQ-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic [IW-1:0]      nxt_owner;
  logic               lock_rel;
  logic [ADDR_W-1:0]  cap_addr;
  logic [3:0]         cap_nbyte;
  logic               cap_rnw;
  logic [DATA_W-1:0]  cap_w_data;

  // While locked only the owner may win; its grant bit doubles as the mask.
  assign cand      = lock_q ? (u_req & grant_q) : u_req;
  assign nxt_owner = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + IW'(1);
  assign lock_rel  = lock_q && (!u_lock[owner_q] || (!u_req[owner_q] && tmo_q == 4'hF));

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i (cand),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    cap_addr   = '0;
    cap_nbyte  = DE_NBYTE_NONE;
    cap_rnw    = 1'b0;
    cap_w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        cap_addr   = u_addr[i*ADDR_W +: ADDR_W];
        cap_nbyte  = u_nbyte[i*4 +: 4];
        cap_rnw    = u_rnw[i];
        cap_w_data = u_w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    tmo_d       = tmo_q;
    de_req_d    = de_req_q;
    de_addr_d   = de_addr_q;
    de_nbyte_d  = de_nbyte_q;
    de_rnw_d    = de_rnw_q;
    de_w_data_d = de_w_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lock_rel) begin
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = nxt_owner;
          tmo_d   = '0;
        end else if (pick_vld) begin
          state_d     = ST_ISSUE;
          grant_d     = pick_gnt;
          owner_d     = pick_idx;
          tmo_d       = '0;
          de_req_d    = 1'b1;
          de_addr_d   = cap_addr;
          de_nbyte_d  = cap_nbyte;
          de_rnw_d    = cap_rnw;
          de_w_data_d = cap_w_data;
        end else if (lock_q) begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      ST_ISSUE: begin
        if (de_ack) begin
          de_req_d = 1'b0;
          lock_d   = u_lock[owner_q];
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        // Requests seen here are stale; the unit drops req one cycle after its ack.
        state_d = ST_IDLE;
        tmo_d   = '0;
        if (!lock_q) begin
          grant_d = '0;
          ptr_d   = nxt_owner;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      tmo_q       <= '0;
      de_req_q    <= 1'b0;
      de_addr_q   <= '0;
      de_nbyte_q  <= DE_NBYTE_NONE;
      de_rnw_q    <= 1'b0;
      de_w_data_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      tmo_q       <= tmo_d;
      de_req_q    <= de_req_d;
      de_addr_q   <= de_addr_d;
      de_nbyte_q  <= de_nbyte_d;
      de_rnw_q    <= de_rnw_d;
      de_w_data_q <= de_w_data_d;
    end
  end

  assign u_ack     = (state_q == ST_ISSUE && de_ack) ? grant_q : '0;
  assign u_r_data  = de_r_data;
  assign de_req    = de_req_q;
  assign de_addr   = de_addr_q;
  assign de_nbyte  = de_nbyte_q;
  assign de_rnw    = de_rnw_q;
  assign de_w_data = de_w_data_q;
  assign grant     = grant_q;

endmodule
